// File: rtl/src_pp_writer.sv
// src_pp_writer: producer side of a ping-pong source buffer. It fills bank ~p from a valid/ready
// stream and hands the tile over with src_fin. Optional macro SRC_PP_LAST_EN adds src_last/tile_words.
module src_pp_writer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [ADDR_W:0]   len,
  input  logic              p,
  input  logic              s_fin_in,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
`ifdef SRC_PP_LAST_EN
  input  logic              src_last,
  output logic [ADDR_W:0]   tile_words,
`endif
  output logic              src_ready,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              src_fin,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FILL, FULL, SWAP} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t          state, state_nxt;
  logic            bank;
  logic [ADDR_W:0] count;
  logic [ADDR_W:0] tile_len;
  logic            accept;
  logic            tile_end;
  logic            handoff;
  logic            swap_go;

  // A zero or oversized length means a full bank.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
    return (l == '0 || l > DEPTH_L) ? DEPTH_L : l;
  endfunction

  assign accept  = src_valid & src_ready;
`ifdef SRC_PP_LAST_EN
  assign tile_end = accept & ((count == tile_len - 1'b1) | src_last);
`else
  assign tile_end = accept & (count == tile_len - 1'b1);
`endif
  assign handoff = (state == FULL) & ~busy;
  assign swap_go = (state == SWAP) & (p == bank);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run)      state_nxt = FILL;
      FILL:    if (tile_end) state_nxt = FULL;
      FULL:    if (!busy)    state_nxt = SWAP;
      SWAP:    if (p == bank) state_nxt = FILL;
      default: state_nxt = IDLE;
    endcase
    if (!run) state_nxt = IDLE;
  end

  always_comb begin
    src_ready = (state == FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank     <= 1'b0;
      count    <= '0;
      tile_len <= DEPTH_L;
      wr_en    <= 1'b0;
      wr_bank  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      src_fin  <= 1'b0;
      busy     <= 1'b0;
    end else if (!run) begin
      bank     <= 1'b0;
      count    <= '0;
      tile_len <= DEPTH_L;
      wr_en    <= 1'b0;
      wr_bank  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      src_fin  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      wr_en   <= accept;
      src_fin <= handoff;
      // handoff only fires with busy=0, so set and clear never collide.
      if (handoff)       busy <= 1'b1;
      else if (s_fin_in) busy <= 1'b0;
      if (accept) begin
        wr_bank <= bank;
        wr_addr <= count[ADDR_W-1:0];
        wr_data <= src_data;
        count   <= count + 1'b1;
      end
      if (state == IDLE || swap_go) begin
        bank     <= (state == IDLE) ? ~p : ~bank;
        count    <= '0;
        tile_len <= clamp_len(len);
      end
    end
  end

`ifdef SRC_PP_LAST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        tile_words <= '0;
    else if (!run)     tile_words <= '0;
    else if (tile_end) tile_words <= count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_src_pp_writer.sv
// Self-checking bench for src_pp_writer: scenario tasks against a queue-based model of tile writes.
module tb_src_pp_writer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic              p = 1'b0;
  logic              s_fin_in = 1'b0;
  logic              src_valid = 1'b0;
  logic [DATA_W-1:0] src_data = '0;
  logic              src_ready;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              src_fin;
  logic              busy;
`ifdef SRC_PP_LAST_EN
  logic              src_last = 1'b0;
  logic [ADDR_W:0]   tile_words;
`endif

  int total = 0;
  int bad = 0;

  src_pp_writer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .len(len), .p(p), .s_fin_in(s_fin_in),
    .src_valid(src_valid), .src_data(src_data),
`ifdef SRC_PP_LAST_EN
    .src_last(src_last), .tile_words(tile_words),
`endif
    .src_ready(src_ready), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .src_fin(src_fin), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Return to IDLE via run=0, then start a tile with the given p and len.
  task automatic restart(input logic pv, input int lv);
    run = 1'b0; src_valid = 1'b0; s_fin_in = 1'b0;
    step();
    total++;
    if ({src_ready, wr_en, wr_bank, src_fin, busy, wr_addr, wr_data} !== '0) begin
      bad++;
      $display("FAIL run_low_clear got rdy=%b we=%b bank=%b fin=%b busy=%b addr=%0d data=%h want all 0",
               src_ready, wr_en, wr_bank, src_fin, busy, wr_addr, wr_data);
    end
    p = pv; len = (ADDR_W+1)'(lv); run = 1'b1;
    step();
  endtask

  // Streams n words (base!=0: base+i, else random) and checks each RAM write in order.
  task automatic fill_tile(input int n, input logic exp_bank, input bit gappy,
                           input logic [DATA_W-1:0] base, input int last_at);
    logic [DATA_W-1:0] q[$];
    int acc = 0;
    int wr = 0;
    bit prev = 1'b0;
    bit done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      total++;
      if (wr_en !== prev) begin
        bad++;
        $display("FAIL wr_en_latency cyc=%0d got=%b want=%b", cyc, wr_en, prev);
      end
      if (wr_en === 1'b1 && wr < q.size()) begin
        total++;
        if ({wr_bank, wr_addr, wr_data} !== {exp_bank, ADDR_W'(wr), q[wr]}) begin
          bad++;
          $display("FAIL write_%0d got bank=%b addr=%0d data=%h want bank=%b addr=%0d data=%h",
                   wr, wr_bank, wr_addr, wr_data, exp_bank, wr, q[wr]);
        end
        wr++;
      end
      if (wr == n) begin
        total++;
        if (src_ready !== 1'b0) begin
          bad++;
          $display("FAIL ready_after_tile got=%b want=0", src_ready);
        end
        src_valid = 1'b0;
`ifdef SRC_PP_LAST_EN
        src_last = 1'b0;
`endif
        done = 1'b1;
      end else begin
        total++;
        if (src_ready !== 1'b1) begin
          bad++;
          $display("FAIL ready_in_fill word=%0d got=%b want=1", acc, src_ready);
        end
        src_valid = gappy ? 1'($urandom % 2) : 1'b1;
        src_data  = (base != '0) ? base + DATA_W'(acc) : DATA_W'($urandom);
`ifdef SRC_PP_LAST_EN
        src_last = src_valid && (acc == last_at);
`endif
        prev = src_valid;
        if (src_valid) begin
          q.push_back(src_data);
          acc++;
        end
        step();
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL fill_timeout got writes=%0d want=%0d", wr, n);
      src_valid = 1'b0;
    end
  endtask

  // Next cycle after the last write: src_fin and busy must rise together.
  task automatic fin_check();
    step();
    total++;
    if ({src_fin, busy, src_ready, wr_en} !== 4'b1100) begin
      bad++;
      $display("FAIL fin_after_tile got fin=%b busy=%b rdy=%b we=%b want 1 1 0 0",
               src_fin, busy, src_ready, wr_en);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0;
    #3;
    total++;
    if ({src_ready, wr_en, wr_bank, src_fin, busy, wr_addr, wr_data} !== '0) begin
      bad++;
      $display("FAIL reset_state got rdy=%b we=%b fin=%b busy=%b want all 0", src_ready, wr_en, src_fin, busy);
    end
`ifdef SRC_PP_LAST_EN
    total++;
    if (tile_words !== '0) begin
      bad++;
      $display("FAIL reset_tile_words got=%0d want=0", tile_words);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if ({src_ready, wr_en, src_fin, busy} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_after_reset got rdy=%b we=%b fin=%b busy=%b want 0", src_ready, wr_en, src_fin, busy);
    end
  endtask

  task automatic test_two_tiles();
    restart(1'b1, 4);
    fill_tile(4, 1'b0, 1'b0, 32'hA0, -1);
    fin_check();
    step();
    total++;
    if ({src_fin, src_ready} !== 2'b00) begin
      bad++;
      $display("FAIL fin_one_cycle got fin=%b rdy=%b want 0 0", src_fin, src_ready);
    end
    p = 1'b0;
    step();
    fill_tile(4, 1'b1, 1'b0, 32'h0, -1);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({src_fin, busy} !== 2'b01) begin
        bad++;
        $display("FAIL hold_while_busy cyc=%0d got fin=%b busy=%b want 0 1", i, src_fin, busy);
      end
    end
    s_fin_in = 1'b1;
    step();
    s_fin_in = 1'b0;
    total++;
    if ({src_fin, busy} !== 2'b00) begin
      bad++;
      $display("FAIL busy_clear got fin=%b busy=%b want 0 0", src_fin, busy);
    end
    step();
    total++;
    if ({src_fin, busy} !== 2'b11) begin
      bad++;
      $display("FAIL fin_after_release got fin=%b busy=%b want 1 1", src_fin, busy);
    end
    s_fin_in = 1'b1;
    step();
    s_fin_in = 1'b0;
    total++;
    if ({src_fin, busy} !== 2'b00) begin
      bad++;
      $display("FAIL clear_in_fin_cycle got fin=%b busy=%b want 0 0", src_fin, busy);
    end
  endtask

  task automatic test_len_clamp();
    restart(1'b0, 0);
    fill_tile(DEPTH, 1'b1, 1'b0, 32'h0, -1);
    fin_check();
    restart(1'b1, 100);
    fill_tile(DEPTH, 1'b0, 1'b0, 32'h0, -1);
    fin_check();
  endtask

  task automatic test_gaps();
    logic pv;
    pv = 1'($urandom % 2);
    restart(pv, 3);
    fill_tile(3, ~pv, 1'b1, 32'h0, -1);
    fin_check();
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if ({src_ready, wr_en} !== 2'b00) begin
        bad++;
        $display("FAIL ready_in_swap cyc=%0d got rdy=%b we=%b want 0 0", i, src_ready, wr_en);
      end
    end
  endtask

  task automatic test_run_drop();
    restart(1'b0, 4);
    src_valid = 1'b1; src_data = $urandom;
    step();
    src_data = $urandom;
    step();
    run = 1'b0; src_valid = 1'b0;
    step();
    total++;
    if ({src_ready, wr_en, wr_bank, src_fin, busy, wr_addr, wr_data} !== '0) begin
      bad++;
      $display("FAIL run_drop got we=%b bank=%b addr=%0d data=%h want all 0", wr_en, wr_bank, wr_addr, wr_data);
    end
    run = 1'b1; len = 7'd4;
    step();
    fill_tile(4, 1'b1, 1'b1, 32'h0, -1);
    fin_check();
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({src_ready, wr_en, wr_bank, src_fin, busy, wr_addr, wr_data} !== '0) begin
      bad++;
      $display("FAIL async_reset got fin=%b busy=%b bank=%b addr=%0d want all 0", src_fin, busy, wr_bank, wr_addr);
    end
    #1;
    rst_n = 1'b1;
  endtask

`ifdef SRC_PP_LAST_EN
  task automatic test_last();
    restart(1'b1, 8);
    fill_tile(3, 1'b0, 1'b0, 32'h0, 2);
    fin_check();
    total++;
    if (tile_words !== 7'd3) begin
      bad++;
      $display("FAIL tile_words got=%0d want=3", tile_words);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic pv;
    logic eb;
    int l;
    int nl;
    pv = 1'($urandom % 2);
    l = $urandom_range(1, 8);
    restart(pv, l);
    eb = ~pv;
    for (int t = 0; t < 5; t++) begin
      fill_tile(l, eb, 1'b1, 32'h0, -1);
      fin_check();
      repeat ($urandom_range(0, 3)) begin
        step();
        total++;
        if (src_ready !== 1'b0) begin
          bad++;
          $display("FAIL b2b_wait_ready tile=%0d got=%b want=0", t, src_ready);
        end
      end
      nl = $urandom_range(1, 8);
      len = (ADDR_W+1)'(nl);
      p = eb; s_fin_in = 1'b1;
      step();
      s_fin_in = 1'b0;
      eb = ~eb;
      l = nl;
    end
  endtask

  initial begin
    test_reset();
    test_two_tiles();
    test_len_clamp();
    test_gaps();
    test_run_drop();
    test_async_reset();
`ifdef SRC_PP_LAST_EN
    test_last();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
